// File: rtl/cpu_step_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_step_ctrl
//   Generates the single-cycle clock-enable that advances the CPU core by one
//   instruction. Three operating modes: continuous run (one pulse per rising
//   edge of the divided slow clock), manual single-step (one pulse per
//   debounced button press) and halt. Everything runs in the board clock
//   domain; the slow clock and the board controls are synchronized first.
//
// Configuration macro:
//   CPU_STEP_SIM_FAST_EN - when defined, the debounce threshold is forced to
//                          4 cycles (fast simulation); otherwise
//                          DEBOUNCE_CYCLES is used.
//
// Ports:
//   clk       in   board clock
//   rst       in   synchronous active-low reset
//   slow_clk  in   divided square wave (asynchronous, synchronized here)
//   step_btn  in   raw active-high push button (bouncing)
//   mode_run  in   raw slide switch, 1 = run, 0 = step
//   halt      in   CPU halt indication, synchronous to clk
//   cpu_en    out  one-clk-wide advance pulse
//   state     out  00 IDLE, 01 RUN, 10 STEP, 11 HALTED
//   step_cnt  out  number of cpu_en pulses issued (wrapping)
// ---------------------------------------------------------------------------
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slow_clk,
    input  logic             step_btn,
    input  logic             mode_run,
    input  logic             halt,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] step_cnt
);

`ifdef CPU_STEP_SIM_FAST_EN
    localparam int DB_TH = 4;
`else
    localparam int DB_TH = DEBOUNCE_CYCLES;
`endif
    // The counter only needs to reach DB_TH-1.
    localparam int             DB_W    = (DB_TH > 1) ? $clog2(DB_TH) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_TH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

    logic             slow_s1_r, slow_s2_r, slow_s3_r;
    logic             btn_s1_r, btn_s2_r;
    logic             mode_s1_r, mode_s2_r;
    logic             tick_s;
    logic             tick_r;
    logic [DB_W-1:0]  db_cnt_r;
    logic             btn_stable_r;
    logic             press_r;
    state_t           state_r;
    logic             cpu_en_r;
    logic [CNT_W-1:0] step_cnt_r;

    // Rising edge of the synchronized slow clock.
    assign tick_s = slow_s2_r & ~slow_s3_r;

    // Two-flop synchronizers, extra slow_clk delay flop, registered tick.
    // Registering the tick puts cpu_en three edges after the slow_clk rise
    // is first sampled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            slow_s1_r <= 1'b0;
            slow_s2_r <= 1'b0;
            slow_s3_r <= 1'b0;
            btn_s1_r  <= 1'b0;
            btn_s2_r  <= 1'b0;
            mode_s1_r <= 1'b0;
            mode_s2_r <= 1'b0;
            tick_r    <= 1'b0;
        end else begin
            slow_s1_r <= slow_clk;
            slow_s2_r <= slow_s1_r;
            slow_s3_r <= slow_s2_r;
            btn_s1_r  <= step_btn;
            btn_s2_r  <= btn_s1_r;
            mode_s1_r <= mode_run;
            mode_s2_r <= mode_s1_r;
            tick_r    <= tick_s;
        end
    end

    // Button debounce: accept a new level only after DB_TH consecutive
    // differing cycles; a press pulse is emitted only on 0->1 acceptance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            db_cnt_r     <= {DB_W{1'b0}};
            btn_stable_r <= 1'b0;
            press_r      <= 1'b0;
        end else if (btn_s2_r != btn_stable_r) begin
            if (db_cnt_r == DB_LAST) begin
                btn_stable_r <= btn_s2_r;
                db_cnt_r     <= {DB_W{1'b0}};
                press_r      <= btn_s2_r;
            end else begin
                db_cnt_r     <= db_cnt_r + DB_W'(1);
                press_r      <= 1'b0;
            end
        end else begin
            db_cnt_r <= {DB_W{1'b0}};
            press_r  <= 1'b0;
        end
    end

    // Mode FSM with registered cpu_en and step counter; halt wins everywhere.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cpu_en_r   <= 1'b0;
            step_cnt_r <= {CNT_W{1'b0}};
        end else begin
            cpu_en_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (halt) begin
                        state_r <= ST_HALTED;
                    end else if (mode_s2_r) begin
                        state_r <= ST_RUN;
                    end else if (press_r) begin
                        state_r <= ST_STEP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (halt) begin
                        state_r <= ST_HALTED;
                    end else if (!mode_s2_r) begin
                        state_r <= ST_IDLE;
                    end else if (tick_r) begin
                        cpu_en_r   <= 1'b1;
                        step_cnt_r <= step_cnt_r + CNT_W'(1);
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_STEP: begin
                    // The single-step pulse is issued on the way out.
                    if (halt) begin
                        state_r <= ST_HALTED;
                    end else begin
                        state_r    <= ST_IDLE;
                        cpu_en_r   <= 1'b1;
                        step_cnt_r <= step_cnt_r + CNT_W'(1);
                    end
                end
                ST_HALTED: begin
                    if (!halt && !mode_s2_r) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_HALTED;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_en   = cpu_en_r;
    assign state    = state_r;
    assign step_cnt = step_cnt_r;

endmodule

// File: doc/cpu_step_ctrl.md
Name: cpu_step_ctrl

Overview:
- Consumes the free-running divided slow clock (~10 Hz square wave from the clock divider) plus the board step button and run switch.
- Produces a single-cycle clock-enable pulse `cpu_en` that advances the CPU core one instruction.
- Supports continuous run (one pulse per slow-clock rising edge), manual single-step (one pulse per debounced button press), and halt.
- Sits between the clock divider and the CPU core; all logic is in the fast board clock domain.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive clk cycles the synchronized button must hold a new level before it is accepted (20 ms at 50 MHz).
- CNT_W, 16, width of the executed-step counter.

Ports:
- clk  input  1  board clock (50 MHz).
- rst  input  1  synchronous active-low reset.
- slow_clk  input  1  divided square wave; asynchronous to the logic's sampling, so it is synchronized.
- step_btn  input  1  raw push button, active-high, bouncing.
- mode_run  input  1  raw slide switch; 1 = run, 0 = step.
- halt  input  1  CPU halt indication, synchronous to clk.
- cpu_en  output  1  one-clk-wide advance pulse to the CPU.
- state  output  2  FSM state: 00 IDLE, 01 RUN, 10 STEP, 11 HALTED.
- step_cnt  output  CNT_W  count of cpu_en pulses issued.

Behaviour:
- Reset (rst==0 at a clk edge):
  - Outputs: cpu_en=0, state=IDLE, step_cnt=0.
  - All synchronizer flops cleared; debounce counter cleared; debounced button = 0.
  - Reset overrides every other event, including mid-pulse or mid-debounce.
- slow_clk, step_btn and mode_run each pass through a 2-flop synchronizer.
- Tick detection:
  - tick = sync2 & ~sync3, where sync3 is a third delay flop on slow_clk.
  - A slow_clk rise sampled at edge k gives tick during the cycle after edge k+2 and cpu_en high after edge k+3.
  - Exactly one tick per slow_clk rising edge.
- Debounce:
  - Counter increments while the synchronized button differs from the stable level.
  - When the counter reaches DEBOUNCE_CYCLES-1, stable <= synchronized level and the counter clears.
  - Any cycle where synchronized == stable clears the counter.
  - press = one-cycle pulse on a stable 0->1 transition; release produces nothing.
- FSM, evaluated every clk; halt has highest priority:
  - IDLE:
    - halt -> HALTED.
    - else mode_run -> RUN.
    - else press -> STEP.
  - RUN:
    - halt -> HALTED, with no pulse even if tick occurs in the same cycle.
    - else !mode_run -> IDLE.
    - else on tick: cpu_en <= 1 for one cycle.
    - press is ignored.
  - STEP:
    - cpu_en <= 1 for exactly one cycle, then -> IDLE next edge, unconditionally unless halt is high (then -> HALTED, pulse still suppressed).
  - HALTED:
    - cpu_en = 0.
    - -> IDLE only when halt==0 and mode_run==0.
    - tick and press are ignored.
- cpu_en is registered, never high in two consecutive cycles, and only high in RUN or on STEP exit.
- step_cnt increments by 1 on the edge where cpu_en is registered high; wraps 2^CNT_W-1 -> 0.
- Presses arriving during STEP or within the same cycle as a transition are dropped; no queuing.

Optional Feature:
- Macro: CPU_STEP_SIM_FAST_EN.
- When defined: effective debounce threshold is forced to 4 cycles regardless of DEBOUNCE_CYCLES, for fast simulation.
- When undefined: DEBOUNCE_CYCLES is used as specified.
- Synchronizers and the FSM are unchanged in both cases.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all inputs toggling -> cpu_en=0, state=00, step_cnt=0; after release state stays 00 with mode_run=0.
- Step with bounce (DEBOUNCE_CYCLES=8): step_btn toggles 5 times within 6 cycles then holds 1 -> exactly one cpu_en pulse after 8 stable cycles plus sync latency, state 00->10->00, step_cnt=1.
- Run: mode_run=1, slow_clk period 40 clk for 5 periods -> 5 cpu_en pulses, each 1 cycle wide, 3 edges after each slow_clk rise; step_cnt=5; press during run -> no extra pulse.
- Halt priority: in RUN, assert halt in the same cycle as tick -> no pulse, state=11; deassert halt with mode_run=1 -> stays 11; set mode_run=0 -> state 00.
- Wrap: CNT_W=4, issue 17 steps -> step_cnt=1.
- Reset mid-debounce: rst=0 at debounce count 5 -> no press generated; stable=0 after release.
